// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: fixed-latency word memory serving cache line fills and write-backs
module data_mem_ctrl #(
    parameter int LATENCY   = 4,
    parameter int ADDR_BITS = 10
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        MemReq,
    input  logic        MemWrite2Memory,
    input  logic [31:0] MissAddr,
    input  logic [31:0] Data2Memory,
    output logic [31:0] ReadData,
    output logic        memory_ready,
    output logic        mem_busy
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t                r_state, w_next;
    logic [3:0]            r_cnt;
    logic [ADDR_BITS-1:0]  r_idx, w_idx;
    logic                  r_we, w_we, w_accept, w_fire;
    logic [31:0]           r_wdata, w_wdata;
    logic [31:0]           r_mem [0:(1<<ADDR_BITS)-1] = '{default: '0};
    logic                  w_unused;

    assign w_unused     = ^{MissAddr[31:ADDR_BITS+2], MissAddr[1:0]};
    assign w_accept     = (r_state == IDLE) && MemReq;
    assign w_idx        = w_accept ? MissAddr[ADDR_BITS+1:2] : r_idx;
    assign w_we         = w_accept ? MemWrite2Memory : r_we;
    assign w_wdata      = w_accept ? Data2Memory : r_wdata;
    assign w_fire       = Reset && (w_next == DONE);
    assign memory_ready = (r_state == DONE);
    assign mem_busy     = (r_state != IDLE);

    // next-state: DONE is entered on the edge the countdown reaches 1, or straight from IDLE when LATENCY is 1
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (MemReq) w_next = (LATENCY == 1) ? DONE : BUSY;
            BUSY:    if (r_cnt == 4'd1) w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    // state, countdown, latched request and read result
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_we     <= 1'b0;
            r_wdata  <= '0;
            ReadData <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_cnt   <= 4'(LATENCY - 1);
                r_idx   <= MissAddr[ADDR_BITS+1:2];
                r_we    <= MemWrite2Memory;
                r_wdata <= Data2Memory;
            end else if (r_state == BUSY) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_fire && !w_we) ReadData <= r_mem[w_idx];
        end
    end

    // array write on the edge entering DONE; contents survive reset
    always_ff @(posedge CLK) begin
        if (w_fire && w_we) r_mem[w_idx] <= w_wdata;
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed and random checks of data_mem_ctrl against a word-array model
module tb_data_mem_ctrl;
    localparam int LATENCY   = 4;
    localparam int ADDR_BITS = 10;
    localparam int WORDS     = 1 << ADDR_BITS;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic        MemReq = 1'b0;
    logic        MemWrite2Memory = 1'b0;
    logic [31:0] MissAddr = '0;
    logic [31:0] Data2Memory = '0;
    logic [31:0] ReadData;
    logic        memory_ready;
    logic        mem_busy;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [31:0] mdl [0:WORDS-1];
    logic [31:0] exp_rd = '0;

    data_mem_ctrl #(.LATENCY(LATENCY), .ADDR_BITS(ADDR_BITS)) dut (
        .CLK(CLK), .Reset(Reset), .MemReq(MemReq), .MemWrite2Memory(MemWrite2Memory),
        .MissAddr(MissAddr), .Data2Memory(Data2Memory), .ReadData(ReadData),
        .memory_ready(memory_ready), .mem_busy(mem_busy)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic int widx(input logic [31:0] a);
        return int'((a / 4) % WORDS);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_req(input string tag, input logic we, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] ga, input logic [31:0] gd);
        int n;
        MemReq = 1'b1; MemWrite2Memory = we; MissAddr = a; Data2Memory = d;
        tick();
        MemReq = 1'b0; MemWrite2Memory = ~we; MissAddr = ga; Data2Memory = gd;
        if (we) mdl[widx(a)] = d;
        else exp_rd = mdl[widx(a)];
        n = 0;
        while (memory_ready !== 1'b1 && n < 20) begin
            chk({tag, "_busy"}, {31'b0, mem_busy}, 32'd1);
            tick();
            n++;
        end
        chk({tag, "_lat"}, n, LATENCY - 1);
        chk({tag, "_rdata"}, ReadData, exp_rd);
        tick();
        chk({tag, "_ready_drop"}, {31'b0, memory_ready}, 32'd0);
        chk({tag, "_idle"}, {31'b0, mem_busy}, 32'd0);
        chk({tag, "_rdata_hold"}, ReadData, exp_rd);
    endtask

    initial begin
        int t0, t1, np, seen;
        logic        we;
        logic [31:0] a, d;
        for (int i = 0; i < WORDS; i++) mdl[i] = '0;
        #2;
        chk("rst_rdata", ReadData, 32'd0);
        chk("rst_ready", {31'b0, memory_ready}, 32'd0);
        chk("rst_busy", {31'b0, mem_busy}, 32'd0);
        tick();
        Reset = 1'b1;
        // first edge after release accepts; write must leave ReadData at 0
        do_req("wr_10", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 32'h0);
        chk("wr_10_rd_zero", ReadData, 32'd0);
        do_req("rd_10", 1'b0, 32'h0000_0010, 32'h0, 32'h0, 32'h0);
        repeat (3) tick();
        chk("rd_10_held", ReadData, 32'hDEAD_BEEF);
        // inputs changed during BUSY are ignored
        do_req("rd_10_chg", 1'b0, 32'h0000_0010, 32'h0, 32'h0000_0020, 32'h0000_1234);
        do_req("rd_20", 1'b0, 32'h0000_0020, 32'h0, 32'h0, 32'h0);
        // MemReq held high across two requests
        MemReq = 1'b1; MemWrite2Memory = 1'b1; MissAddr = 32'h30; Data2Memory = 32'hA5A5_0F0F;
        tick();
        mdl[widx(32'h30)] = 32'hA5A5_0F0F;
        MemWrite2Memory = 1'b0; Data2Memory = 32'h0;
        np = 0; t0 = 0; t1 = 0;
        for (int i = 0; i < 30 && np < 2; i++) begin
            if (memory_ready === 1'b1) begin
                if (np == 0) t0 = cyc;
                else t1 = cyc;
                np++;
                if (np == 2) MemReq = 1'b0;
            end
            if (np < 2) tick();
        end
        chk("b2b_pulses", np, 2);
        chk("b2b_gap", t1 - t0, LATENCY + 1);
        chk("b2b_rdata", ReadData, 32'hA5A5_0F0F);
        tick();
        chk("b2b_idle", {31'b0, mem_busy}, 32'd0);
        // reset two cycles into a write discards it
        MemReq = 1'b1; MemWrite2Memory = 1'b1; MissAddr = 32'h40; Data2Memory = 32'hCAFE_F00D;
        tick();
        MemReq = 1'b0;
        tick(); tick();
        Reset = 1'b0;
        #1;
        exp_rd = '0;
        chk("rst_mid_busy", {31'b0, mem_busy}, 32'd0);
        chk("rst_mid_ready", {31'b0, memory_ready}, 32'd0);
        chk("rst_mid_rdata", ReadData, 32'd0);
        seen = 0;
        tick(); tick();
        Reset = 1'b1;
        repeat (LATENCY + 3) begin
            if (memory_ready === 1'b1) seen++;
            tick();
        end
        chk("rst_no_pulse", seen, 0);
        do_req("rd_40", 1'b0, 32'h0000_0040, 32'h0, 32'h0, 32'h0);
        // aliasing of upper address bits and ignored byte offset
        do_req("wr_1004", 1'b1, 32'h0000_1004, 32'h5555_AAAA, 32'h0, 32'h0);
        do_req("rd_0004", 1'b0, 32'h0000_0004, 32'h0, 32'h0, 32'h0);
        chk("alias_val", ReadData, 32'h5555_AAAA);
        do_req("rd_0007", 1'b0, 32'hFFFF_F007, 32'h0, 32'h0, 32'h0);
        // random mix on a small set of word indices
        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom_range(0, 1));
            a  = {20'($urandom), 10'($urandom_range(0, 7) * 129), 2'($urandom_range(0, 3))};
            d  = $urandom;
            do_req("rnd", we, a, d, $urandom, $urandom);
            if ($urandom_range(0, 3) == 0) tick();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
